// File: rtl/fib_job_arbiter.sv
// Round-robin front end sharing one iterative Fibonacci engine among NREQ requesters.
// Latency: done arrives n cycles after the grant cycle (one cycle for n=0); requests wait, req held, while the engine is busy.
module fib_job_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int NW   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NW-1:0]       n_in,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [W-1:0]             result,
    output logic                     overflow,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [NW-1:0]   n_lat_q, n_lat_d;
    logic [W-1:0]    prev_q, prev_d;
    logic [W-1:0]    cur_q, cur_d;
    logic [NW-1:0]   cnt_q, cnt_d;

    logic [NW-1:0]   n_arr [NREQ];
    logic            any_req;
    logic [OW-1:0]   sel;
    logic [OW-1:0]   idx;
    logic [W:0]      sum;
    logic            job_end;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            n_arr[i] = n_in[i*NW +: NW];
        end
    end

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    assign sum     = {1'b0, cur_q} + {1'b0, prev_q};
    assign job_end = (n_lat_q == '0) || (cnt_q == n_lat_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
            n_lat_q    <= '0;
            prev_q     <= '0;
            cur_q      <= W'(1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            n_lat_q    <= n_lat_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = RUN;
            RUN:     if (job_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = '0;
        done_d     = '0;
        result_d   = result_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        n_lat_d    = n_lat_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d[sel] = 1'b1;
                    owner_d    = sel;
                    n_lat_d    = n_arr[sel];
                    prev_d     = '0;
                    cur_d      = W'(1);
                    cnt_d      = NW'(1);
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
                    ptr_d      = (sel == OW'(NREQ - 1)) ? '0 : sel + OW'(1);
                end
            end
            RUN: begin
                if (n_lat_q == '0) begin
                    done_d[owner_q] = 1'b1;
                    result_d        = '0;
                    overflow_d      = 1'b0;
                    busy_d          = 1'b0;
                end else if (cnt_q == n_lat_q) begin
                    done_d[owner_q] = 1'b1;
                    result_d        = cur_q;
                    busy_d          = 1'b0;
                end else begin
                    // cur tracks F(cnt); the carry makes overflow sticky for the job.
                    cur_d      = sum[W-1:0];
                    prev_d     = cur_q;
                    cnt_d      = cnt_q + NW'(1);
                    overflow_d = overflow_q | sum[W];
                end
            end
            default: ;
        endcase
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_fib_job_arbiter.sv
// Scoreboard bench for fib_job_arbiter: directed jobs queue expected grants and completions.
module tb_fib_job_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int NW   = 6;
    localparam int OW   = 2;

    typedef struct {
        int     owner;
        int     n;
        longint res;
        bit     ovf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req;
    logic [NREQ*NW-1:0]  n_in = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [W-1:0]        result;
    logic                overflow;
    logic                busy;
    logic [OW-1:0]       owner;

    int tgt  [NREQ] = '{default: 0};
    int gcnt [NREQ] = '{default: 0};
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_g = 0;
    int last_d = -1;
    exp_t exp_done[$];
    int   exp_gnt[$];

    fib_job_arbiter #(.NREQ(NREQ), .W(W), .NW(NW)) dut (
        .clk(clk), .rst(rst), .req(req), .n_in(n_in),
        .gnt(gnt), .done(done), .result(result), .overflow(overflow),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // A requester keeps req high until it has received as many grants as jobs asked of it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) req[i] = (gcnt[i] < tgt[i]);
    end

    function automatic void chk(string nm, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst && (|gnt)) begin
                int gi;
                gi = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
                chk("gnt_onehot", longint'($onehot(gnt)), 1);
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", gi, -1);
                end else begin
                    chk("gnt_owner", gi, exp_gnt.pop_front());
                end
                chk("busy_at_gnt", busy, 1);
                chk("owner_at_gnt", owner, gi);
                chk("gnt_after_done", longint'(cyc > last_d), 1);
                gcnt[gi]++;
                last_g = cyc;
            end
            if (rst && (|done)) begin
                chk("no_gnt_with_done", gnt, 0);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    exp_t d;
                    d = exp_done.pop_front();
                    chk("done_vec", done, longint'(1) << d.owner);
                    chk("done_owner", owner, d.owner);
                    chk("result", result, d.res);
                    chk("overflow", overflow, d.ovf);
                    chk("done_cycle", cyc - last_g, (d.n == 0) ? 1 : d.n);
                    chk("busy_at_done", busy, 0);
                end
                last_d = cyc;
            end
        end
    end

    task automatic issue(input int i, input int n, input longint res, input bit ovf);
        exp_t e;
        e.owner = i; e.n = n; e.res = res; e.ovf = ovf;
        exp_gnt.push_back(i);
        exp_done.push_back(e);
        n_in[i*NW +: NW] = NW'(n);
        tgt[i]++;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (exp_gnt.size() != 0 || exp_done.size() != 0); c++)
            @(negedge clk);
        chk("drain_timeout", exp_gnt.size() + exp_done.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_gnt(input int i);
        for (int c = 0; c < 100 && gcnt[i] < tgt[i]; c++) @(negedge clk);
        chk("gnt_timeout", gcnt[i], tgt[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Round-robin from pointer 0: order 0,1,2,3,0, each F(3)=2.
        issue(0, 3, 2, 0);
        issue(1, 3, 2, 0);
        issue(2, 3, 2, 0);
        issue(3, 3, 2, 0);
        issue(0, 3, 2, 0);
        drain(200);

        issue(0, 10, 55, 0);
        drain(100);
        chk("busy_after_job", busy, 0);
        issue(1, 1, 1, 0);
        drain(50);
        issue(2, 2, 1, 0);
        drain(50);
        issue(3, 0, 0, 0);
        drain(50);

        issue(1, 47, 64'd2971215073, 0);
        drain(100);
        issue(1, 48, 64'd512559680, 1);
        drain(100);
        issue(1, 5, 5, 0);
        drain(50);

        // n_in changes after the grant must not affect the running job.
        issue(0, 10, 55, 0);
        wait_gnt(0);
        n_in[0 +: NW] = NW'(20);
        drain(100);

        issue(2, 4, 3, 0);
        issue(2, 4, 3, 0);
        drain(100);

        // Reset four cycles into an n=10 job on requester 1; no done may follow.
        exp_gnt.push_back(1);
        n_in[1*NW +: NW] = NW'(10);
        tgt[1]++;
        wait_gnt(1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midjob_reset");
        rst = 1'b1;
        repeat (15) @(negedge clk);

        // Pointer restarted at 0: requester 0 beats 3.
        issue(0, 2, 1, 0);
        issue(3, 2, 1, 0);
        drain(100);
        chk("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fib_job_arbiter.md
Name: fib_job_arbiter

Overview:
- Shared Fibonacci engine with a round-robin front end for NREQ requesters.
- Each requester asks for term F(n) of the sequence 1, 1, 2, 3, 5, ...
- The block grants one requester at a time, latches its n, and runs an iterative previous/current adder for n steps.
- It returns the term with a one-cycle done pulse to the owner, then re-arbitrates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, width of the adder and result.
- NW, 6, width of each requested index n.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- req  input  NREQ  per-requester request level.
- n_in  input  NREQ*NW  packed indices; requester i uses bits [i*NW +: NW].
- gnt  output  NREQ  one-hot grant pulse, one cycle.
- done  output  NREQ  one-hot completion pulse, one cycle.
- result  output  W  F(n) of the finishing job; valid only while done != 0.
- overflow  output  1  the finishing job wrapped mod 2^W; valid with done.
- busy  output  1  high while a job is active (RUN state).
- owner  output  clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; gnt, done, result, overflow, busy, owner all 0.
  - Round-robin pointer = 0; internal prev=0, cur=1, cnt=0.
  - Reset mid-job abandons the job: no done is ever issued for it.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - If any req is high, select the first requester with req=1, scanning from the pointer upward and wrapping.
  - At that edge latch n_lat=n_in[sel], owner=sel, prev=0, cur=1, cnt=1, overflow=0.
  - Also set gnt[sel]=1 for exactly the next cycle, busy=1, pointer=(sel+1) mod NREQ; go to RUN.
  - If no req is high, stay in IDLE with outputs idle.
- RUN, per cycle:
  - If n_lat==0: done[owner]=1, result=0, overflow=0; go to IDLE.
  - Else if cnt==n_lat: done[owner]=1, result=cur, busy=0; go to IDLE.
  - Else: {carry, sum}=cur+prev (W+1 bits); cur<=sum; prev<=cur; cnt<=cnt+1; overflow<=overflow|carry.
- Timing, with G = the cycle gnt is high:
  - done is high in cycle G+n for n>=1, and in cycle G+1 for n=0.
  - The next gnt can appear no earlier than the cycle after done.
  - done and gnt are never high in the same cycle.
- Handshake:
  - A requester holds req until it sees gnt.
  - n_in is sampled only at the grant edge; later changes are ignored.
  - Dropping req during RUN does not cancel the job; done still fires.
  - req still high in the done cycle, or after it, counts as a new request and competes under round-robin.
- Arithmetic:
  - result = F(n) mod 2^W, with F(1)=F(2)=1.
  - overflow is sticky for the job and cleared at each grant.
  - For W=32: F(47)=2971215073 has no overflow; F(48) has overflow.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0 with no starvation.
- Simultaneous requests: only the pointer-priority winner is granted; the others wait, with req held.

Test Plan:
- Single job: req[0]=1, n=10 → gnt[0] in cycle G; done[0] in G+10; result=55; overflow=0; busy low after.
- Edge indices: n=1 → result=1 at G+1. n=2 → result=1 at G+2. n=0 → result=0 at G+1.
- Overflow: n=47 → result=2971215073, overflow=0. n=48 → result=512559680, overflow=1. A following n=5 job → result=5, overflow=0.
- Round-robin: all four req held, n=3 each → grant order 0,1,2,3,0. Each done carries result=2 and the correct owner. No gnt overlaps a done.
- Mid-job events:
  - n_in changed after grant (10→20) → result=55.
  - req dropped during RUN → done still pulses.
  - rst=0 at cycle G+4 of an n=10 job → all outputs 0, no done; the next request is served from pointer 0.
- Back-to-back: req[2] held high with n=4 → gnt at G, done at G+4, next gnt at G+5 or later; each job returns result=3.
